pow3_ctrl: RTL and testbench
============================

Name: pow3_ctrl

Overview:
- Stream-side sequencer placed directly in front of the iterative cube unit (ports start/x/xpower/finished).
- Accepts operands on a valid/ready input stream, pulses start, waits for finished and captures xpower into a small result FIFO.
- Presents results on a valid/ready output stream, so the cube unit can sit in a back-pressured datapath.
- Adds a timeout watchdog on the cube unit.

Parameters:
W, 8, operand/result width; must match the cube unit.
DEPTH, 2, result FIFO depth (>=1).
TIMEOUT, 8, max WAIT cycles before abort (>=4).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operand valid.
in_data  in  W  operand x.
in_ready  out  1  operand accepted when in_valid&&in_ready at posedge.
p_start  out  1  to cube unit start; one-cycle pulse.
p_x  out  W  to cube unit x; held stable from START through WAIT.
p_xpower  in  W  from cube unit xpower.
p_finished  in  1  from cube unit finished.
out_valid  out  1  FIFO head valid.
out_data  out  W  FIFO head = x^3 mod 2^W.
out_ready  in  1  consumer pop when out_valid&&out_ready.
busy  out  1  state != IDLE.
err_timeout  out  1  sticky; set on watchdog abort.

Behaviour:
- Reset (async, clk not required): state=IDLE; FIFO empty; p_start=0; p_x=0; out_valid=0; out_data=0; err_timeout=0; timer=0.
- States:
  - IDLE: in_ready=(fifo_count<DEPTH). On accept, latch in_data into p_x and go to START.
  - START: p_start=1 for exactly this cycle; in_ready=0; next state WAIT; timer cleared.
  - WAIT: in_ready=0; p_start=0; timer increments each cycle.
    - If p_finished=1: push p_xpower into FIFO and go to IDLE.
    - Else if timer==TIMEOUT-1: set err_timeout, push nothing, go to IDLE.
- p_finished is ignored outside WAIT. The cube unit has no reset, so finished is X/stale at power-up and after rst; this is harmless because the cube unit's start overrides its internal state.
- Cube timing: after the START edge, finished=0 for 2 cycles and =1 in the 3rd WAIT cycle.
- Required latency: accept edge -> out_valid high 4 clocks later (START, WAIT x3, push). Throughput: 1 result per 5 clocks.
- Arithmetic: the controller performs none; results are the cube unit's W-bit truncated product (mod 2^W), stored unmodified.
- FIFO:
  - Ordering: first-in first-out.
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - Push when full: impossible by construction, since accept requires a free slot and only one operation is in flight. Assert in simulation.
  - Pop when empty: ignored.
  - Wrap-around: pointers wrap modulo DEPTH.
- out_data/out_valid are driven from registers; no combinational path from out_ready to out_valid.
- in_ready depends only on state and fifo_count, not on in_valid.
- rst mid-operation: everything returns to reset values immediately; any in-flight operand is dropped; a later START restarts the cube unit cleanly.
- err_timeout is cleared only by rst.

Decomposition:
- Package pow3_pkg:
  - state enum {IDLE, START, WAIT}.
  - Default constants for W, DEPTH, TIMEOUT.
  - Timer width = $clog2(TIMEOUT+1).
- Sub-module pow3_res_fifo: synchronous FIFO with W-bit data and DEPTH entries; ports push, pop, din, dout, count, full, empty; async active-high rst.
- The FSM and watchdog stay in pow3_ctrl.

Test Plan:
- Single operand, x=3, out_ready=1: p_start pulses once; out_data=27 appears 4 clocks after accept; busy high for 4 cycles.
- Truncation: x=7 -> out_data=87 (343 mod 256); x=255 -> 255; x=0 -> 0.
- Back-pressure: out_ready=0, send 2, 3, 4 with DEPTH=2. FIFO holds 8, 27 and in_ready stays low while 4 is pending. Raise out_ready: pops 8, 27, then 64, in order.
- Simultaneous push/pop: FIFO holding 8, pop on the same edge 27 is pushed. Count stays 1, head becomes 27.
- Watchdog: cube model holds finished=0. err_timeout rises after 8 WAIT cycles; nothing is pushed; FSM returns to IDLE and accepts x=2 -> 8.
- Reset mid-WAIT: assert rst in the 2nd WAIT cycle. All outputs return to reset values asynchronously. After release, x=5 -> out_data=125 (no stale data).

Source files
------------

// File: rtl/pow3_pkg.sv
// Shared types and default parameters for the pow3 stream sequencer.
package pow3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int W_DEF       = 8;
  localparam int DEPTH_DEF   = 2;
  localparam int TIMEOUT_DEF = 8;

  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pow3_ctrl_if.sv
// Operand and result streams of the pow3 sequencer.
interface pow3_ctrl_if import pow3_pkg::*; #(
  parameter int W = W_DEF
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  // slave: the sequencer itself; master: whoever feeds operands and drains results
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
endinterface

// File: rtl/pow3_res_fifo.sv
// Small synchronous result FIFO with registered storage, plus its overflow checker.
module pow3_res_fifo import pow3_pkg::*; #(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == {CW{1'b0}});
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {W{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module pow3_push_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  // An accept always reserves a slot, so a push can never meet a full FIFO.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/pow3_ctrl.sv
// Sequencer in front of the iterative cube unit: operand stream in, start/finished
// handshake with watchdog, results buffered in a FIFO and streamed out.
module pow3_ctrl import pow3_pkg::*; #(
  parameter int W       = W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  pow3_ctrl_if.slave   s_if,
  output logic         p_start,
  output logic [W-1:0] p_x,
  input  logic [W-1:0] p_xpower,
  input  logic         p_finished,
  output logic         busy,
  output logic         err_timeout
);
  localparam int TW = timer_w(TIMEOUT);
  localparam int CW = $clog2(DEPTH + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [W-1:0]  r_p_x;
  logic          r_p_start;
  logic          r_err;
  logic          w_accept;
  logic          w_push;
  logic          w_abort;
  logic          w_in_ready;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic [W-1:0]  w_dout;

  assign w_in_ready     = (r_state == IDLE) && (w_count < CW'(DEPTH));
  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = !w_empty;
  assign s_if.out_data  = w_dout;
  assign p_start        = r_p_start;
  assign p_x            = r_p_x;
  assign busy           = (r_state != IDLE);
  assign err_timeout    = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // p_finished only matters in WAIT; it is stale/X everywhere else.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_if.in_valid && w_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: w_state_nxt = WAIT;
      WAIT: begin
        if (p_finished) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_x     <= {W{1'b0}};
      r_p_start <= 1'b0;
      r_timer   <= {TW{1'b0}};
      r_err     <= 1'b0;
    end else begin
      if (w_accept) r_p_x <= s_if.in_data;
      r_p_start <= (w_state_nxt == START);
      if (r_state == START)     r_timer <= {TW{1'b0}};
      else if (r_state == WAIT) r_timer <= r_timer + TW'(1);
      if (w_abort) r_err <= 1'b1;
    end
  end

  pow3_res_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (s_if.out_ready),
    .din   (p_xpower),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  pow3_push_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .full (w_full)
  );
endmodule

// File: tb/tb_pow3_ctrl.sv
// Directed bench for pow3_ctrl with a behavioural 3-cycle cube unit model.
module tb_pow3_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       p_start;
  logic [7:0] p_x;
  logic [7:0] p_xpower;
  logic       p_finished;
  logic       busy;
  logic       err_timeout;

  int n_vec = 0;
  int n_err = 0;

  pow3_ctrl_if #(.W(8)) u_if ();

  pow3_ctrl #(.W(8), .DEPTH(2), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (u_if),
    .p_start     (p_start),
    .p_x         (p_x),
    .p_xpower    (p_xpower),
    .p_finished  (p_finished),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Cube unit model: finished in the 3rd cycle after the start edge; no reset.
  logic [7:0] cm_x = 8'd0;
  int         cm_cnt = 0;
  logic       cm_hang = 1'b0;
  always @(posedge clk) begin
    if (p_start) begin
      cm_x   <= p_x;
      cm_cnt <= 1;
    end else if (cm_cnt == 3) begin
      cm_cnt <= 0;
    end else if (cm_cnt != 0) begin
      cm_cnt <= cm_cnt + 1;
    end
  end
  assign p_finished = (cm_cnt == 3) && !cm_hang;
  assign p_xpower   = 8'(cm_x * cm_x * cm_x);

  typedef struct {
    logic [7:0] x;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] x);
    u_if.in_valid = 1'b1;
    u_if.in_data  = x;
    tick();
    u_if.in_valid = 1'b0;
  endtask

  // One operand with the consumer always ready: latency, data, start pulse, busy span.
  task automatic run_vec(input logic [7:0] x, input logic [7:0] exp);
    int lat;
    int starts;
    int busys;
    int k;
    check("in_ready_idle", int'(u_if.in_ready), 1);
    u_if.out_ready = 1'b1;
    send(x);
    check("p_x_latched", int'(p_x), int'(x));
    lat = -1; starts = 0; busys = 0; k = 0;
    while (lat < 0 && k < 12) begin
      if (u_if.out_valid) begin
        lat = k;
      end else begin
        if (p_start) starts++;
        if (busy) busys++;
        tick();
        k++;
      end
    end
    check("latency", lat, 4);
    check("out_data", int'(u_if.out_data), int'(exp));
    check("start_pulses", starts, 1);
    check("busy_cycles", busys, 4);
  endtask

  logic [7:0] got[$];
  logic       acc;

  initial begin
    tbl[0] = '{8'd3,   8'd27};
    tbl[1] = '{8'd7,   8'd87};
    tbl[2] = '{8'd255, 8'd255};
    tbl[3] = '{8'd0,   8'd0};
    tbl[4] = '{8'd2,   8'd8};
    tbl[5] = '{8'd10,  8'd232};
    tbl[6] = '{8'd9,   8'd217};
    tbl[7] = '{8'd16,  8'd0};

    u_if.in_valid  = 1'b0;
    u_if.in_data   = 8'd0;
    u_if.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_p_start", int'(p_start), 0);
    check("rst_p_x", int'(p_x), 0);
    check("rst_out_valid", int'(u_if.out_valid), 0);
    check("rst_out_data", int'(u_if.out_data), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(tbl[i].x, tbl[i].exp);
    tick();
    check("drained", int'(u_if.out_valid), 0);

    // Back-pressure: 8 and 27 fill the FIFO, 4 must wait.
    u_if.out_ready = 1'b0;
    send(8'd2);
    repeat (4) tick();
    send(8'd3);
    repeat (4) tick();
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'd4;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready_low", int'(u_if.in_ready), 0);
      check("bp_idle", int'(busy), 0);
      tick();
    end
    check("bp_head", int'(u_if.out_data), 8);
    got.delete();
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 40 && got.size() < 3; k++) begin
      if (u_if.out_valid) got.push_back(u_if.out_data);
      acc = u_if.in_valid && u_if.in_ready;
      tick();
      if (acc) u_if.in_valid = 1'b0;
    end
    u_if.in_valid = 1'b0;
    check("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      check("bp_pop0", int'(got[0]), 8);
      check("bp_pop1", int'(got[1]), 27);
      check("bp_pop2", int'(got[2]), 64);
    end
    tick();
    check("bp_empty", int'(u_if.out_valid), 0);

    // Push of 27 and pop of 8 on the same edge.
    u_if.out_ready = 1'b0;
    send(8'd2);
    repeat (4) tick();
    check("pp_hold8", int'(u_if.out_data), 8);
    send(8'd3);
    repeat (3) tick();
    u_if.out_ready = 1'b1;
    tick();
    check("pp_valid", int'(u_if.out_valid), 1);
    check("pp_head27", int'(u_if.out_data), 27);
    tick();
    check("pp_one_left", int'(u_if.out_valid), 0);

    // Watchdog abort.
    cm_hang = 1'b1;
    send(8'd2);
    repeat (8) tick();
    check("wd_err_early", int'(err_timeout), 0);
    check("wd_busy_wait8", int'(busy), 1);
    tick();
    check("wd_err_set", int'(err_timeout), 1);
    check("wd_idle", int'(busy), 0);
    check("wd_no_push", int'(u_if.out_valid), 0);
    cm_hang = 1'b0;
    tick();
    run_vec(8'd2, 8'd8);
    check("wd_err_sticky", int'(err_timeout), 1);
    tick();

    // Reset in the 2nd WAIT cycle.
    send(8'd9);
    repeat (2) tick();
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_p_x", int'(p_x), 0);
    check("mid_rst_p_start", int'(p_start), 0);
    check("mid_rst_err", int'(err_timeout), 0);
    check("mid_rst_out_valid", int'(u_if.out_valid), 0);
    check("mid_rst_out_data", int'(u_if.out_data), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_no_stale", int'(u_if.out_valid), 0);
    run_vec(8'd5, 8'd125);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
